// File: rtl/dual_rail_ctrl_array.sv
// N_CH-channel dual-rail R_c/R_m controller with DATA/NULL
// wavefront sequencing, stability filter, ko/ki handshake and error trap.
module dual_rail_ctrl_array #(
  parameter int N_CH       = 4,
  parameter int STABLE_CYC = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  ph0_t,
  input  logic [N_CH-1:0]  ph0_f,
  input  logic [N_CH-1:0]  ph1_t,
  input  logic [N_CH-1:0]  ph1_f,
  input  logic [N_CH-1:0]  rd_t,
  input  logic [N_CH-1:0]  rd_f,
  input  logic [N_CH-1:0]  ld_t,
  input  logic [N_CH-1:0]  ld_f,
  input  logic             ki,
  input  logic             clr_err,
  output logic [N_CH-1:0]  r_c_t,
  output logic [N_CH-1:0]  r_c_f,
  output logic [N_CH-1:0]  r_m_t,
  output logic [N_CH-1:0]  r_m_f,
  output logic             ko,
  output logic             err,
  output logic [CNT_W-1:0] wave_cnt
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);

  typedef enum logic [1:0] {
    S_NULL,
    S_DATA,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   stab;
  logic [SW-1:0]   stab_nx;
  logic [SW-1:0]   stab_inc;
  logic            hit;
  logic            illegal;
  logic            all_data;
  logic            all_null;
  logic            ld_data;
  logic            wave_inc;
  logic [N_CH-1:0] rc;
  logic [N_CH-1:0] rm;

  assign illegal = |((ph0_t & ph0_f) | (ph1_t & ph1_f)
                   | (rd_t & rd_f) | (ld_t & ld_f));

  assign all_data = &((ph0_t ^ ph0_f) & (ph1_t ^ ph1_f)
                    & (rd_t ^ rd_f) & (ld_t ^ ld_f));

  assign all_null = ~|(ph0_t | ph0_f | ph1_t | ph1_f
                    | rd_t | rd_f | ld_t | ld_f);

  // Only meaningful under all_data, where the true rail is the value.
  assign rc = ~ph0_t & ph1_t & rd_t;
  assign rm = ph0_t | (ph1_t & ld_t);

  assign stab_inc = stab + 1'b1;
  assign hit      = (stab_inc == STAB_MAX);

  always_comb begin
    state_nx = state;
    stab_nx  = '0;
    ld_data  = 1'b0;
    wave_inc = 1'b0;
    if (illegal) begin
      state_nx = S_ERR;
    end else begin
      case (state)
        S_NULL: begin
          if (all_data && ki) begin
            if (hit) begin
              state_nx = S_DATA;
              ld_data  = 1'b1;
            end else begin
              stab_nx = stab_inc;
            end
          end
        end
        S_DATA: begin
          if (all_null && !ki) begin
            if (hit) begin
              state_nx = S_NULL;
              wave_inc = 1'b1;
            end else begin
              stab_nx = stab_inc;
            end
          end
        end
        S_ERR: begin
          if (all_null && clr_err) begin
            state_nx = S_NULL;
          end
        end
        default: state_nx = S_NULL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_NULL;
      stab     <= '0;
      r_c_t    <= '0;
      r_c_f    <= '0;
      r_m_t    <= '0;
      r_m_f    <= '0;
      ko       <= 1'b1;
      err      <= 1'b0;
      wave_cnt <= '0;
    end else begin
      state <= state_nx;
      stab  <= stab_nx;
      ko    <= (state_nx == S_NULL);
      err   <= (state_nx == S_ERR);
      if (ld_data) begin
        r_c_t <= rc;
        r_c_f <= ~rc;
        r_m_t <= rm;
        r_m_f <= ~rm;
      end else if (state_nx != S_DATA) begin
        r_c_t <= '0;
        r_c_f <= '0;
        r_m_t <= '0;
        r_m_f <= '0;
      end
      if (wave_inc) begin
        wave_cnt <= wave_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_rail_ctrl_array.sv
// Bench for dual_rail_ctrl_array: STABLE_CYC=1 and =3 instances
// on shared stimulus, checked against a wavefront-level model.
module tb_dual_rail_ctrl_array;

  logic       clk;
  logic       rst_n;
  logic [3:0] ph0_t, ph0_f, ph1_t, ph1_f;
  logic [3:0] rd_t, rd_f, ld_t, ld_f;
  logic       ki;
  logic       clr_err;

  logic [3:0] rct [2];
  logic [3:0] rcf [2];
  logic [3:0] rmt [2];
  logic [3:0] rmf [2];
  logic       ko  [2];
  logic       err [2];
  logic [7:0] wc  [2];

  int md  [2];
  int cnt [2];
  int wv  [2];
  logic [3:0] e_rct [2];
  logic [3:0] e_rcf [2];
  logic [3:0] e_rmt [2];
  logic [3:0] e_rmf [2];
  int stab_req [2] = '{1, 3};

  int n_chk  = 0;
  int n_fail = 0;

  dual_rail_ctrl_array #(.N_CH(4), .STABLE_CYC(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ph0_t(ph0_t), .ph0_f(ph0_f), .ph1_t(ph1_t), .ph1_f(ph1_f),
    .rd_t(rd_t), .rd_f(rd_f), .ld_t(ld_t), .ld_f(ld_f),
    .ki(ki), .clr_err(clr_err),
    .r_c_t(rct[0]), .r_c_f(rcf[0]), .r_m_t(rmt[0]), .r_m_f(rmf[0]),
    .ko(ko[0]), .err(err[0]), .wave_cnt(wc[0])
  );

  dual_rail_ctrl_array #(.N_CH(4), .STABLE_CYC(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ph0_t(ph0_t), .ph0_f(ph0_f), .ph1_t(ph1_t), .ph1_f(ph1_f),
    .rd_t(rd_t), .rd_f(rd_f), .ld_t(ld_t), .ld_f(ld_f),
    .ki(ki), .clr_err(clr_err),
    .r_c_t(rct[1]), .r_c_f(rcf[1]), .r_m_t(rmt[1]), .r_m_f(rmf[1]),
    .ko(ko[1]), .err(err[1]), .wave_cnt(wc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: md 0=waiting for DATA, 1=holding DATA, 2=error trap.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        md[k] <= 0; cnt[k] <= 0; wv[k] <= 0;
        e_rct[k] <= '0; e_rcf[k] <= '0;
        e_rmt[k] <= '0; e_rmf[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin : mdl
        automatic int m = md[k];
        automatic int c = cnt[k];
        automatic int w = wv[k];
        automatic logic [3:0] a = e_rct[k], b = e_rcf[k];
        automatic logic [3:0] d = e_rmt[k], e = e_rmf[k];
        automatic logic [15:0] tt = {ph0_t, ph1_t, rd_t, ld_t};
        automatic logic [15:0] ff = {ph0_f, ph1_f, rd_f, ld_f};
        automatic int n_ill = 0, n_dat = 0, n_nul = 0;
        for (int i = 0; i < 16; i++) begin
          if (tt[i] && ff[i]) n_ill++;
          else if (!tt[i] && !ff[i]) n_nul++;
          else n_dat++;
        end
        if (n_ill > 0) begin
          m = 2; c = 0; a = 0; b = 0; d = 0; e = 0;
        end else if (m == 0) begin
          if (n_dat == 16 && ki) begin
            c++;
            if (c == stab_req[k]) begin
              m = 1; c = 0;
              for (int ch = 0; ch < 4; ch++) begin
                a[ch] = !ph0_t[ch] && ph1_t[ch] && rd_t[ch];
                d[ch] = ph0_t[ch] || (ph1_t[ch] && ld_t[ch]);
                b[ch] = !a[ch];
                e[ch] = !d[ch];
              end
            end
          end else c = 0;
        end else if (m == 1) begin
          if (n_nul == 16 && !ki) begin
            c++;
            if (c == stab_req[k]) begin
              m = 0; c = 0; w = (w + 1) % 256;
              a = 0; b = 0; d = 0; e = 0;
            end
          end else c = 0;
        end else begin
          c = 0;
          if (n_nul == 16 && clr_err) m = 0;
        end
        md[k] <= m; cnt[k] <= c; wv[k] <= w;
        e_rct[k] <= a; e_rcf[k] <= b;
        e_rmt[k] <= d; e_rmf[k] <= e;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("r_c_t%0d", k), 32'(rct[k]), 32'(e_rct[k]));
      check($sformatf("r_c_f%0d", k), 32'(rcf[k]), 32'(e_rcf[k]));
      check($sformatf("r_m_t%0d", k), 32'(rmt[k]), 32'(e_rmt[k]));
      check($sformatf("r_m_f%0d", k), 32'(rmf[k]), 32'(e_rmf[k]));
      check($sformatf("ko%0d", k), 32'(ko[k]), 32'(md[k] == 0));
      check($sformatf("err%0d", k), 32'(err[k]), 32'(md[k] == 2));
      check($sformatf("wave%0d", k), 32'(wc[k]), 32'(wv[k] % 256));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(int c, logic p0, logic p1, logic rd, logic ld);
    ph0_t[c] = p0; ph0_f[c] = !p0;
    ph1_t[c] = p1; ph1_f[c] = !p1;
    rd_t[c]  = rd; rd_f[c]  = !rd;
    ld_t[c]  = ld; ld_f[c]  = !ld;
  endtask

  task automatic set_null();
    ph0_t = '0; ph0_f = '0; ph1_t = '0; ph1_f = '0;
    rd_t  = '0; rd_f  = '0; ld_t  = '0; ld_f  = '0;
  endtask

  task automatic set_zero_data();
    for (int c = 0; c < 4; c++) set_ch(c, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; ki = 1'b1; clr_err = 1'b0;
    set_null();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check("rst_ko", 32'(ko[0]), 32'd1);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_wave", 32'(wc[0]), 32'd0);
    check("rst_rct", 32'(rct[0]), 32'd0);

    set_zero_data();
    set_ch(0, 0, 1, 1, 0);
    ki = 1'b1;
    cyc(1);
    check("t2_rct", 32'(rct[0]), 32'h1);
    check("t2_rcf", 32'(rcf[0]), 32'he);
    check("t2_rmt", 32'(rmt[0]), 32'h0);
    check("t2_rmf", 32'(rmf[0]), 32'hf);
    check("t2_ko", 32'(ko[0]), 32'd0);
    cyc(2);
    set_null(); ki = 1'b0;
    cyc(1);
    check("t2_null_ko", 32'(ko[0]), 32'd1);
    check("t2_wave", 32'(wc[0]), 32'd1);
    check("t2_null_rct", 32'(rct[0]), 32'd0);
    cyc(2);

    for (int j = 0; j < 16; j++) begin
      for (int c = 0; c < 4; c++) begin
        automatic logic [3:0] v = 4'((j + 5 * c) % 16);
        set_ch(c, v[3], v[2], v[1], v[0]);
      end
      ki = 1'b1;
      cyc(3);
      if (j == 5) begin
        check("t3_0101_rc", 32'(rcf[0][0]), 32'd1);
        check("t3_0101_rm", 32'(rmt[0][0]), 32'd1);
      end
      if (j == 8) begin
        check("t3_1xxx_rc", 32'(rcf[0][0]), 32'd1);
        check("t3_1xxx_rm", 32'(rmt[0][0]), 32'd1);
      end
      if (j == 7) begin
        check("t3_0111_rc", 32'(rct[0][0]), 32'd1);
        check("t3_0111_rm", 32'(rmt[0][0]), 32'd1);
      end
      set_null(); ki = 1'b0;
      cyc(3);
    end

    set_zero_data();
    ph0_t[2] = 0; ph0_f[2] = 0; ph1_t[2] = 0; ph1_f[2] = 0;
    rd_t[2]  = 0; rd_f[2]  = 0; ld_t[2]  = 0; ld_f[2]  = 0;
    ki = 1'b1;
    cyc(5);
    check("t4_part_ko", 32'(ko[0]), 32'd1);
    check("t4_part_rcf", 32'(rcf[0]), 32'd0);
    set_zero_data();
    cyc(2);
    set_ch(2, 0, 0, 0, 0);
    ph0_f[2] = 1'b0;
    cyc(1);
    set_zero_data();
    cyc(2);
    check("t4_glitch_ko_b", 32'(ko[1]), 32'd1);
    cyc(1);
    check("t4_clean_ko_b", 32'(ko[1]), 32'd0);
    set_null(); ki = 1'b0;
    cyc(3);

    set_zero_data(); ki = 1'b1;
    cyc(2);
    ki = 1'b0;
    cyc(1);
    ki = 1'b1;
    cyc(2);
    check("t4_ki_ko_b", 32'(ko[1]), 32'd1);
    cyc(1);
    check("t4_ki_acc_b", 32'(ko[1]), 32'd0);
    set_null(); ki = 1'b0;
    cyc(3);

    set_zero_data(); ki = 1'b1;
    cyc(3);
    ph1_t[1] = 1'b1; ph1_f[1] = 1'b1;
    cyc(1);
    check("t5_err", 32'(err[0]), 32'd1);
    check("t5_ko", 32'(ko[0]), 32'd0);
    check("t5_rcf", 32'(rcf[0]), 32'd0);
    check("t5_err_b", 32'(err[1]), 32'd1);
    set_zero_data(); clr_err = 1'b1;
    cyc(2);
    check("t5_clr_ign", 32'(err[0]), 32'd1);
    set_null();
    cyc(1);
    check("t5_clr_err", 32'(err[0]), 32'd0);
    check("t5_clr_ko", 32'(ko[0]), 32'd1);
    clr_err = 1'b0;
    cyc(1);

    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    for (int i = 0; i < 256; i++) begin
      set_zero_data(); ki = 1'b1;
      cyc(3);
      set_null(); ki = 1'b0;
      cyc(3);
      if (i == 254) check("t6_wave255", 32'(wc[0]), 32'd255);
    end
    check("t6_wrap_a", 32'(wc[0]), 32'd0);
    check("t6_wrap_b", 32'(wc[1]), 32'd0);

    set_zero_data(); set_ch(3, 1, 0, 0, 0); ki = 1'b1;
    cyc(1);
    check("t6_data_ko", 32'(ko[0]), 32'd0);
    check("t6_data_rmt", 32'(rmt[0]), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_rmt", 32'(rmt[0]), 32'd0);
    check("t6_arst_rcf", 32'(rcf[0]), 32'd0);
    check("t6_arst_ko", 32'(ko[0]), 32'd1);
    check("t6_arst_wave", 32'(wc[0]), 32'd0);
    cyc(1);
    set_null(); rst_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
